// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-time ROM-to-RAM copier.
//   state_e        : copier FSM states
//   WORD_W         : data/address width
//   DEF_BOOT_*     : default auto-boot source, destination and length
package boot_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_BOOT_SRC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_BOOT_DST = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_BOOT_LEN = 32'd1024;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/rom_boot_copier_if.sv
// Control, ROM read and RAM write signals of the boot copier.
//   master : the copier (drives ROM address, RAM write, status)
//   slave  : the SoC side (drives start/config, ROM data, RAM ready)
interface rom_boot_copier_if;
  import boot_pkg::*;

  logic              start;
  logic [WORD_W-1:0] src_base;
  logic [WORD_W-1:0] dst_base;
  logic [WORD_W-1:0] len;
  logic [WORD_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_rdata;
  logic              ram_we;
  logic [WORD_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic              ram_ready;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] checksum;
  logic              cpu_rst_n;

  modport master (
    input  start, src_base, dst_base, len, rom_rdata, ram_ready,
    output rom_addr, ram_we, ram_addr, ram_wdata, busy, done, checksum, cpu_rst_n
  );

  modport slave (
    output start, src_base, dst_base, len, rom_rdata, ram_ready,
    input  rom_addr, ram_we, ram_addr, ram_wdata, busy, done, checksum, cpu_rst_n
  );

endinterface

// File: rtl/boot_skid_buf.sv
// One-entry skid register. Holds a ROM word that returns while the RAM
// write register is stalled.
//   clk, rst_n : clock, async active-low reset
//   push_i/data_i : capture a word (push wins over a same-cycle pop)
//   pop_i      : release the held word
//   valid_o/data_o : held word
module boot_skid_buf
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (pop_i) valid_d = 1'b0;
    if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rom_boot_copier.sv
// Boot-time DMA: streams words from a 1-cycle-latency ROM into RAM,
// accumulating an additive checksum, and holds the CPU in reset until the
// first copy completes.
//   clk, rst_n : clock, async active-low reset
//   bus        : master side of rom_boot_copier_if (start/config, ROM read,
//                RAM write with ready backpressure, busy/done/checksum/cpu_rst_n)
module rom_boot_copier
  import boot_pkg::*;
#(
  parameter logic [WORD_W-1:0] BOOT_SRC  = DEF_BOOT_SRC,
  parameter logic [WORD_W-1:0] BOOT_DST  = DEF_BOOT_DST,
  parameter logic [WORD_W-1:0] BOOT_LEN  = DEF_BOOT_LEN,
  parameter bit                AUTO_BOOT = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  rom_boot_copier_if.master  bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] dst_q, dst_d, len_q, len_d;
  logic [WORD_W-1:0] issued_q, issued_d, accepted_q, accepted_d;
  logic [WORD_W-1:0] rom_addr_q, rom_addr_d, wdata_q, wdata_d, csum_q, csum_d;
  logic              out_v_q, out_v_d, rvalid_q, rvalid_d;
  logic              boot_pend_q, boot_pend_d, cpu_rst_n_q, cpu_rst_n_d;

  logic              skid_v, skid_push, skid_pop;
  logic [WORD_W-1:0] skid_data;
  logic              accept, load, issue, go;
  logic [WORD_W-1:0] go_src, go_dst, go_len;

  boot_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (skid_push),
    .data_i  (bus.rom_rdata),
    .pop_i   (skid_pop),
    .valid_o (skid_v),
    .data_o  (skid_data)
  );

  assign accept = out_v_q & bus.ram_ready;
  assign load   = ~out_v_q | bus.ram_ready;
  // Issuing only with an empty skid guarantees the returning word always has
  // a slot: the output register if it moves on, otherwise the skid.
  assign issue  = (state_q == StRun) & ~skid_v & load;
  assign go     = (state_q == StIdle) & (boot_pend_q | bus.start);
  assign go_src = boot_pend_q ? BOOT_SRC : bus.src_base;
  assign go_dst = boot_pend_q ? BOOT_DST : bus.dst_base;
  assign go_len = boot_pend_q ? BOOT_LEN : bus.len;

  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    len_d       = len_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    rom_addr_d  = rom_addr_q;
    wdata_d     = wdata_q;
    csum_d      = csum_q;
    out_v_d     = out_v_q;
    rvalid_d    = issue;
    boot_pend_d = boot_pend_q;
    cpu_rst_n_d = cpu_rst_n_q;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;

    // Output register: skid word takes priority, it is always older.
    if (load) begin
      out_v_d = skid_v | rvalid_q;
      if (skid_v) begin
        wdata_d  = skid_data;
        skid_pop = 1'b1;
      end else if (rvalid_q) begin
        wdata_d = bus.rom_rdata;
      end
    end else if (rvalid_q) begin
      skid_push = 1'b1;
    end

    if (accept) begin
      accepted_d = accepted_q + 32'd1;
      csum_d     = csum_q + wdata_q;
    end

    unique case (state_q)
      StIdle: begin
        if (go) begin
          boot_pend_d = 1'b0;
          dst_d       = go_dst;
          len_d       = go_len;
          rom_addr_d  = go_src;
          issued_d    = '0;
          accepted_d  = '0;
          csum_d      = '0;
          state_d     = (go_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue) begin
          rom_addr_d = rom_addr_q + 32'd1;
          issued_d   = issued_q + 32'd1;
          if (issued_q + 32'd1 == len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (accept && (accepted_q + 32'd1 == len_q)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StDone) cpu_rst_n_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dst_q       <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      rom_addr_q  <= '0;
      wdata_q     <= '0;
      csum_q      <= '0;
      out_v_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      boot_pend_q <= AUTO_BOOT;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      rom_addr_q  <= rom_addr_d;
      wdata_q     <= wdata_d;
      csum_q      <= csum_d;
      out_v_q     <= out_v_d;
      rvalid_q    <= rvalid_d;
      boot_pend_q <= boot_pend_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // Words are accepted in order, so the accept count indexes the current word.
  assign bus.rom_addr  = rom_addr_q;
  assign bus.ram_we    = out_v_q;
  assign bus.ram_addr  = dst_q + accepted_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.busy      = (state_q == StRun) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone);
  assign bus.checksum  = csum_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;

endmodule
